truth_table_checker: RTL and testbench
======================================

# truth_table_checker

Sequential response checker for the elementary two-input logic gates: the receiving end of the gate stimulus stream. It accepts (A, B, Y) samples over a valid/ready handshake and compares each Y against a parameterised 4-entry truth table. It accumulates pass/fail counts, input-combination coverage and the first failing vector, and pulses `done` once all four combinations have been seen. It sits beside any gate under test, in simulation benches and in the on-board self-test path.

## Interface
- `TRUTH`, 4'b1000, expected Y indexed by {A,B} (bit0 = A0B0 … bit3 = A1B1); default is AND
- `CNT_W`, 8, width of pass/fail counters (≥2)

- `clk`  in  1  rising-edge clock, single domain
- `reset`  in  1  synchronous, active-high
- `clear`  in  1  synchronous clear of counters/coverage/first-fail; lower priority than `reset`
- `in_valid`  in  1  sample present
- `in_ready`  out  1  checker can accept
- `a`, `b`  in  1 each  gate inputs applied
- `y`  in  1  gate output observed
- `pass_count`  out  CNT_W  matching samples, saturating
- `fail_count`  out  CNT_W  mismatching samples, saturating
- `coverage`  out  4  bit {a,b} set once that combination was checked
- `mismatch`  out  1  one-cycle pulse per failing sample
- `first_fail_valid`  out  1  a failure has been captured
- `first_fail_vec`  out  3  {a,b,y} of first failure
- `done`  out  1  one-cycle pulse when `coverage` first reaches 4'b1111

## Operation
- FSM states: IDLE, CHECK, REPORT.
- IDLE: `in_ready`=1. On `in_valid && in_ready`, register {a,b,y} → CHECK.
- CHECK: `in_ready`=0. Compute expected = `TRUTH[{a,b}]`.
  - Equal: `pass_count`+1.
  - Else: `fail_count`+1, `mismatch`=1. If `!first_fail_valid`, capture vector and set flag.
  - Set `coverage[{a,b}]`.
  - If coverage becomes 4'b1111 this cycle, go to REPORT (only once per clear/reset epoch). Otherwise go to IDLE.
- REPORT: `done`=1, `in_ready`=0, for exactly one cycle → IDLE.
- Counters saturate at 2^CNT_W−1 and never wrap; saturation does not block coverage or first-fail updates.
- Repeated combinations re-count but never re-trigger `done`.
- `clear` in any state:
  - Zeroes counters, coverage, first-fail and the done-epoch flag.
  - Aborts an in-flight CHECK without counting it. FSM → IDLE.
  - A sample handshaken in the same cycle as `clear` is discarded.
- `reset` mid-operation: identical to clear plus FSM → IDLE. No pulse outputs the following cycle.

## Timing
- Reset values: `in_ready`=0 while `reset`=1 and 1 from the first cycle after release. All counts/coverage/flags/vector = 0. `mismatch`=0, `done`=0.
- Handshake: transfer on a rising edge with `in_valid && in_ready`. Source holds a/b/y stable while `in_valid`=1 and `in_ready`=0.
- Latency: sample accepted at edge N. `pass_count`/`fail_count`/`coverage`/`first_fail_*` and `mismatch` are valid after edge N+1.
- `done` is high in the cycle after edge N+1 (REPORT), then clears at edge N+2.
- Throughput: one sample per 2 cycles, or 3 cycles for the sample that completes coverage.
- All outputs registered, except `in_ready`, which is decoded from state.

## Structure
- Package `gate_check_pkg`:
  - state enum (IDLE/CHECK/REPORT)
  - truth constants TT_AND=4'b1000, TT_OR=4'b1110, TT_NAND=4'b0111, TT_NOR=4'b0001, TT_XOR=4'b0110
- Sub-module `sat_counter` (parameter W; inputs clk, reset, clear, inc; output count), instantiated twice for pass/fail.
- FSM, capture registers and coverage in the top module.

## Test plan
- TRUTH=TT_AND; apply (0,0,0),(0,1,0),(1,0,0),(1,1,1) back-to-back valid → pass=4, fail=0, coverage=4'b1111, one `done` pulse in the cycle after the 4th sample's check, `mismatch` never high.
- TRUTH=TT_AND; samples (1,1,0) then (0,1,1) → fail=2, `mismatch` pulses twice, first_fail_vec=3'b110 and remains after the second failure.
- CNT_W=2; send (1,1,1) six times → pass_count holds 3, coverage=4'b1000, no `done`.
- Hold `in_valid`=1 continuously → `in_ready` toggles 1,0 per sample, and 1,0,0 around the covering sample. No sample lost or double-counted: 4 samples give pass+fail=4.
- Assert `clear` during CHECK of the 3rd sample → counts/coverage = 0 next cycle; resend all 4 → `done` pulses again, pass=4.
- Assert `reset` one cycle while REPORT is pending → `done` never pulses, all outputs 0, `in_ready`=1 the cycle after release.

Source files
------------

// File: rtl/gate_check_pkg.sv
// ----------------------------------------------------------------------------
// gate_check_pkg
//   Shared types and constants for the gate response checker.
//   - state_t      : checker FSM states (IDLE / CHECK / REPORT)
//   - TT_*         : 4-entry truth tables for the elementary two-input gates,
//                    indexed by {a,b} (bit0 = a0b0 ... bit3 = a1b1)
//   - COV_FULL     : coverage value once every {a,b} combination was checked
//   - expected_y() : truth-table lookup for one {a,b} combination
// ----------------------------------------------------------------------------
package gate_check_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      CHECK  = 2'd1,
      REPORT = 2'd2
   } state_t;

   localparam logic [3:0] TT_AND  = 4'b1000;
   localparam logic [3:0] TT_OR   = 4'b1110;
   localparam logic [3:0] TT_NAND = 4'b0111;
   localparam logic [3:0] TT_NOR  = 4'b0001;
   localparam logic [3:0] TT_XOR  = 4'b0110;

   localparam logic [3:0] COV_FULL = 4'b1111;

   // Expected gate output for inputs (a,b) under the given truth table.
   function automatic logic expected_y(input logic [3:0] truth,
                                       input logic       a,
                                       input logic       b);
      return truth[{a, b}];
   endfunction

endpackage : gate_check_pkg

// File: rtl/truth_table_checker_sat_counter.sv
// ----------------------------------------------------------------------------
// sat_counter
//   Saturating up-counter used for the pass and fail tallies.
//   Ports:
//     clk    : rising-edge clock
//     reset  : synchronous active-high reset, highest priority
//     clear  : synchronous clear, below reset
//     inc    : count one event this cycle
//     count  : current value; sticks at all-ones instead of wrapping
//   Parameter:
//     W      : counter width
// ----------------------------------------------------------------------------
module sat_counter #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         clear,
   input  logic         inc,
   output logic [W-1:0] count
);

   localparam logic [W-1:0] COUNT_MAX = '1;

   logic [W-1:0] count_reg;

   always_ff @(posedge clk) begin
      if (reset) begin
         count_reg <= '0;
      end else if (clear) begin
         count_reg <= '0;
      end else if (inc && (count_reg != COUNT_MAX)) begin
         count_reg <= count_reg + 1'b1;
      end
   end

   assign count = count_reg;

endmodule : sat_counter

// File: rtl/truth_table_checker.sv
// ----------------------------------------------------------------------------
// truth_table_checker
//   Receiving end of a two-input gate stimulus stream. Each accepted (a,b,y)
//   sample is compared against the TRUTH table one cycle after acceptance.
//   Pass/fail tallies, {a,b} coverage and the first failing vector are kept
//   until reset or clear; done pulses once per epoch when coverage fills.
//
//   Parameters:
//     TRUTH : expected y indexed by {a,b} (default AND)
//     CNT_W : width of the saturating pass/fail counters
//   Ports:
//     clk, reset        : clock, synchronous active-high reset
//     clear             : synchronous clear of all accumulated results
//     in_valid/in_ready : sample handshake (transfer when both high)
//     a, b, y           : gate inputs applied and gate output observed
//     pass_count        : matching samples (saturating)
//     fail_count        : mismatching samples (saturating)
//     coverage          : bit {a,b} set once that combination was checked
//     mismatch          : one-cycle pulse per failing sample
//     first_fail_valid  : a failure has been captured
//     first_fail_vec    : {a,b,y} of the first failure
//     done              : one-cycle pulse when coverage first fills
// ----------------------------------------------------------------------------
module truth_table_checker
   import gate_check_pkg::*;
#(
   parameter logic [3:0] TRUTH = TT_AND,
   parameter int         CNT_W = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clear,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             a,
   input  logic             b,
   input  logic             y,
   output logic [CNT_W-1:0] pass_count,
   output logic [CNT_W-1:0] fail_count,
   output logic [3:0]       coverage,
   output logic             mismatch,
   output logic             first_fail_valid,
   output logic [2:0]       first_fail_vec,
   output logic             done
);

   state_t     state_reg;
   logic [2:0] vec_reg;             // captured {a,b,y}
   logic [3:0] coverage_reg;
   logic       mismatch_reg;
   logic       first_fail_valid_reg;
   logic [2:0] first_fail_vec_reg;
   logic       done_reg;
   logic       done_epoch_reg;      // done already fired since last reset/clear

   logic       in_check;
   logic       sample_ok;
   logic [3:0] cov_bit;             // one-hot of the captured {a,b}
   logic [3:0] coverage_next;
   logic       pass_inc;
   logic       fail_inc;

   // ------------------------------------------------------------------
   // Check datapath on the captured sample
   // ------------------------------------------------------------------
   assign in_check  = (state_reg == CHECK);
   assign sample_ok = (vec_reg[0] == expected_y(TRUTH, vec_reg[2], vec_reg[1]));

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_cov_dec
         assign cov_bit[gi] = (vec_reg[2:1] == 2'(gi));
      end
   endgenerate

   assign coverage_next = coverage_reg | cov_bit;

   // Counters apply reset/clear priority internally, so an in-flight
   // check aborted by clear never reaches the tally.
   assign pass_inc = in_check &&  sample_ok;
   assign fail_inc = in_check && !sample_ok;

   sat_counter #(.W(CNT_W)) u_pass_cnt (
      .clk   (clk),
      .reset (reset),
      .clear (clear),
      .inc   (pass_inc),
      .count (pass_count)
   );

   sat_counter #(.W(CNT_W)) u_fail_cnt (
      .clk   (clk),
      .reset (reset),
      .clear (clear),
      .inc   (fail_inc),
      .count (fail_count)
   );

   // ------------------------------------------------------------------
   // Control FSM with capture, coverage and first-fail registers
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset || clear) begin
         // Both return to a clean epoch; a sample handshaken in this
         // cycle is dropped because the capture below is skipped.
         state_reg            <= IDLE;
         vec_reg              <= '0;
         coverage_reg         <= '0;
         mismatch_reg         <= 1'b0;
         first_fail_valid_reg <= 1'b0;
         first_fail_vec_reg   <= '0;
         done_reg             <= 1'b0;
         done_epoch_reg       <= 1'b0;
      end else begin
         // Pulse outputs default low; set only on the cycle they fire.
         mismatch_reg <= 1'b0;
         done_reg     <= 1'b0;

         case (state_reg)
            IDLE: begin
               if (in_valid) begin
                  vec_reg   <= {a, b, y};
                  state_reg <= CHECK;
               end
            end

            CHECK: begin
               coverage_reg <= coverage_next;
               if (!sample_ok) begin
                  mismatch_reg <= 1'b1;
                  if (!first_fail_valid_reg) begin
                     first_fail_valid_reg <= 1'b1;
                     first_fail_vec_reg   <= vec_reg;
                  end
               end
               // Coverage only ever grows within an epoch, so the epoch
               // flag is what keeps repeats from re-firing done.
               if ((coverage_next == COV_FULL) && !done_epoch_reg) begin
                  done_reg       <= 1'b1;
                  done_epoch_reg <= 1'b1;
                  state_reg      <= REPORT;
               end else begin
                  state_reg <= IDLE;
               end
            end

            REPORT: begin
               state_reg <= IDLE;
            end

            default: begin
               state_reg <= IDLE;
            end
         endcase
      end
   end

   // Ready is decoded from state; held low while reset is asserted.
   assign in_ready         = (state_reg == IDLE) && !reset;

   assign coverage         = coverage_reg;
   assign mismatch         = mismatch_reg;
   assign first_fail_valid = first_fail_valid_reg;
   assign first_fail_vec   = first_fail_vec_reg;
   assign done             = done_reg;

endmodule : truth_table_checker

// File: tb/tb_truth_table_checker.sv
// ----------------------------------------------------------------------------
// tb_truth_table_checker
//   Two checkers share one stimulus stream: an 8-bit AND checker and a
//   2-bit AND checker (to exercise saturation). A behavioural model tracks
//   what every output must be; directed phases pin the model with literal
//   expectations and a random phase follows.
// ----------------------------------------------------------------------------
module tb_truth_table_checker;
   import gate_check_pkg::*;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic clear = 1'b0;
   logic in_valid = 1'b0;
   logic a = 1'b0;
   logic b = 1'b0;
   logic y = 1'b0;

   logic       rdy_a, mis_a, ffv_a, done_a;
   logic [7:0] pass_a, fail_a;
   logic [3:0] cov_a;
   logic [2:0] ffvec_a;

   logic       rdy_s, mis_s, ffv_s, done_s;
   logic [1:0] pass_s, fail_s;
   logic [3:0] cov_s;
   logic [2:0] ffvec_s;

   int total = 0;
   int bad = 0;

   always #5 clk = ~clk;

   truth_table_checker #(.TRUTH(TT_AND), .CNT_W(8)) dut_a (
      .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid),
      .in_ready(rdy_a), .a(a), .b(b), .y(y),
      .pass_count(pass_a), .fail_count(fail_a), .coverage(cov_a),
      .mismatch(mis_a), .first_fail_valid(ffv_a), .first_fail_vec(ffvec_a),
      .done(done_a)
   );

   truth_table_checker #(.TRUTH(TT_AND), .CNT_W(2)) dut_s (
      .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid),
      .in_ready(rdy_s), .a(a), .b(b), .y(y),
      .pass_count(pass_s), .fail_count(fail_s), .coverage(cov_s),
      .mismatch(mis_s), .first_fail_valid(ffv_s), .first_fail_vec(ffvec_s),
      .done(done_s)
   );

   task automatic cmp(input string nm, input int inst,
                      input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s[%0d] got=%0h want=%0h at %0t", nm, inst, act, exp, $time);
      end
   endtask

   // ------------------------------------------------------------------
   // Behavioural model: a sample accepted at one edge is judged at the
   // next; the sample that completes coverage costs one extra cycle.
   // ------------------------------------------------------------------
   logic [3:0] tt_v[2]  = '{TT_AND, TT_AND};
   int         max_v[2] = '{255, 3};

   int         m_pass[2], m_fail[2];
   logic [3:0] m_cov[2];
   bit         m_mis[2], m_done[2], m_ffv[2], m_pend[2], m_busy[2], m_epoch[2];
   logic [2:0] m_ffvec[2], m_vec[2];
   bit         acc_last = 1'b0;
   bit         chk_en = 1'b0;

   always @(posedge clk) begin
      acc_last = 1'b0;
      for (int i = 0; i < 2; i++) begin
         if (reset || clear) begin
            m_pass[i] = 0; m_fail[i] = 0; m_cov[i] = 4'h0;
            m_mis[i] = 0; m_done[i] = 0; m_ffv[i] = 0; m_ffvec[i] = 3'b000;
            m_pend[i] = 0; m_busy[i] = 0; m_epoch[i] = 0;
            if (reset) chk_en = 1'b1;
         end else begin
            m_mis[i]  = 0;
            m_done[i] = 0;
            if (m_pend[i]) begin
               logic ey;
               ey = tt_v[i][m_vec[i][2:1]];
               if (m_vec[i][0] == ey) begin
                  if (m_pass[i] < max_v[i]) m_pass[i]++;
               end else begin
                  if (m_fail[i] < max_v[i]) m_fail[i]++;
                  m_mis[i] = 1;
                  if (!m_ffv[i]) begin
                     m_ffv[i] = 1;
                     m_ffvec[i] = m_vec[i];
                  end
               end
               m_cov[i][m_vec[i][2:1]] = 1'b1;
               if (m_cov[i] == 4'hF && !m_epoch[i]) begin
                  m_done[i] = 1; m_epoch[i] = 1; m_busy[i] = 1;
               end
               m_pend[i] = 0;
               if (i == 0)
                  $display("txn a=%0d b=%0d y=%0d expect=%0d %s pass=%0d bad_cnt=%0d cov=%b",
                           m_vec[i][2], m_vec[i][1], m_vec[i][0], ey,
                           (m_vec[i][0] == ey) ? "ok" : "wrong", m_pass[i], m_fail[i], m_cov[i]);
            end else if (m_busy[i]) begin
               m_busy[i] = 0;
            end else if (in_valid) begin
               m_pend[i] = 1;
               m_vec[i]  = {a, b, y};
               if (i == 0) acc_last = 1'b1;
            end
         end
      end
   end

   // ------------------------------------------------------------------
   // Per-cycle compare on the falling edge
   // ------------------------------------------------------------------
   int done_cnt_a = 0, done_cnt_s = 0, mis_cnt_a = 0;

   always @(negedge clk) begin
      if (chk_en) begin
         cmp("ready",    0, rdy_a,   !reset && !m_pend[0] && !m_busy[0]);
         cmp("ready",    1, rdy_s,   !reset && !m_pend[1] && !m_busy[1]);
         cmp("pass",     0, pass_a,  m_pass[0]);
         cmp("pass",     1, pass_s,  m_pass[1]);
         cmp("fail_cnt", 0, fail_a,  m_fail[0]);
         cmp("fail_cnt", 1, fail_s,  m_fail[1]);
         cmp("coverage", 0, cov_a,   m_cov[0]);
         cmp("coverage", 1, cov_s,   m_cov[1]);
         cmp("mism",     0, mis_a,   m_mis[0]);
         cmp("mism",     1, mis_s,   m_mis[1]);
         cmp("ffv",      0, ffv_a,   m_ffv[0]);
         cmp("ffv",      1, ffv_s,   m_ffv[1]);
         cmp("ffvec",    0, ffvec_a, m_ffvec[0]);
         cmp("ffvec",    1, ffvec_s, m_ffvec[1]);
         cmp("done",     0, done_a,  m_done[0]);
         cmp("done",     1, done_s,  m_done[1]);
         if (done_a === 1'b1) done_cnt_a++;
         if (done_s === 1'b1) done_cnt_s++;
         if (mis_a === 1'b1)  mis_cnt_a++;
      end
   end

   // ------------------------------------------------------------------
   // Stimulus helpers: inputs change 1 time unit after the falling edge
   // ------------------------------------------------------------------
   task automatic send(input logic [2:0] v);
      bit got;
      got = 1'b0;
      in_valid = 1'b1;
      {a, b, y} = v;
      for (int n = 0; n < 10 && !got; n++) begin
         @(negedge clk);
         got = acc_last;
      end
      total++;
      if (!got) begin
         bad++;
         $display("FAIL accept vec=%b got=no want=yes at %0t", v, $time);
      end
      #1;
   endtask

   task automatic idle(input int n);
      in_valid = 1'b0;
      repeat (n) @(negedge clk);
      #1;
   endtask

   task automatic pulse_clear();
      in_valid = 1'b0;
      clear = 1'b1;
      @(negedge clk);
      #1;
      clear = 1'b0;
   endtask

   logic [2:0] and_vecs[4] = '{3'b000, 3'b010, 3'b100, 3'b111};

   initial begin
      int d0, ds0, mm0;
      repeat (3) @(negedge clk);
      cmp("rst_ready", 0, rdy_a, 1'b0);
      #1 reset = 1'b0;
      @(negedge clk);
      cmp("post_rst_ready", 0, rdy_a, 1'b1);
      cmp("post_rst_pass", 0, pass_a, 0);
      #1;

      // AND truth table, back-to-back valid
      d0 = done_cnt_a; ds0 = done_cnt_s; mm0 = mis_cnt_a;
      for (int i = 0; i < 4; i++) send(and_vecs[i]);
      idle(4);
      cmp("and_pass", 0, pass_a, 4);
      cmp("and_fail", 0, fail_a, 0);
      cmp("and_cov", 0, cov_a, 4'b1111);
      cmp("and_done_pulses", 0, done_cnt_a - d0, 1);
      cmp("and_mism_pulses", 0, mis_cnt_a - mm0, 0);
      cmp("and_total", 0, pass_a + fail_a, 4);
      cmp("sat_pass", 1, pass_s, 3);
      cmp("sat_done_pulses", 1, done_cnt_s - ds0, 1);

      // Two failures; first vector is retained
      pulse_clear();
      mm0 = mis_cnt_a;
      send(3'b110);
      send(3'b011);
      idle(3);
      cmp("two_fail", 0, fail_a, 2);
      cmp("two_mism_pulses", 0, mis_cnt_a - mm0, 2);
      cmp("first_vec", 0, ffvec_a, 3'b110);
      cmp("first_valid", 0, ffv_a, 1'b1);

      // Saturation with a single combination repeated
      pulse_clear();
      ds0 = done_cnt_s;
      repeat (6) send(3'b111);
      idle(3);
      cmp("sat_hold", 1, pass_s, 3);
      cmp("sat_cov", 1, cov_s, 4'b1000);
      cmp("sat_no_done", 1, done_cnt_s - ds0, 0);
      cmp("wide_pass", 0, pass_a, 6);

      // Clear aborts the check of the third sample
      pulse_clear();
      send(and_vecs[0]);
      send(and_vecs[1]);
      send(and_vecs[2]);
      pulse_clear();
      cmp("clr_pass", 0, pass_a, 0);
      cmp("clr_cov", 0, cov_a, 4'b0000);
      d0 = done_cnt_a;
      for (int i = 0; i < 4; i++) send(and_vecs[i]);
      idle(4);
      cmp("reclr_done", 0, done_cnt_a - d0, 1);
      cmp("reclr_pass", 0, pass_a, 4);

      // Reset while REPORT is pending
      pulse_clear();
      d0 = done_cnt_a;
      for (int i = 0; i < 4; i++) send(and_vecs[i]);
      in_valid = 1'b0;
      reset = 1'b1;
      @(negedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      cmp("rst_rdy_after", 0, rdy_a, 1'b1);
      cmp("rst_pass", 0, pass_a, 0);
      cmp("rst_cov", 0, cov_a, 4'b0000);
      #1;
      idle(3);
      cmp("rst_no_done", 0, done_cnt_a - d0, 0);

      // Randomized traffic with occasional clear and reset
      for (int c = 0; c < 600; c++) begin
         if (!(in_valid && !acc_last)) begin
            in_valid = ($urandom_range(0, 3) != 0);
            {a, b, y} = 3'($urandom_range(0, 7));
         end
         clear = ($urandom_range(0, 39) == 0);
         reset = ($urandom_range(0, 99) == 0);
         @(negedge clk);
         #1;
      end
      clear = 1'b0;
      reset = 1'b0;
      idle(5);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout want=finish");
      $fatal(1, "watchdog expired");
   end

endmodule : tb_truth_table_checker
